// File: rtl/na_sweep_sequencer_pkg.sv
// Shared definitions for the network-analyzer sweep sequencer.
// The sequencer and the IQ block's own register decoder both use these constants.
package na_sweep_sequencer_pkg;

    localparam int POINTBITS_DEF   = 16;
    localparam int TIMEOUTBITS_DEF = 8;

    // IQ-block averaging-engine addresses
    localparam logic [15:0] FREQ_ADDR = 16'h0108;
    localparam logic [15:0] SUM_ADDR  = 16'h0140;

    // PS-side register map
    localparam logic [15:0] REG_CTRL   = 16'h0000;
    localparam logic [15:0] REG_START  = 16'h0004;
    localparam logic [15:0] REG_STEP   = 16'h0008;
    localparam logic [15:0] REG_POINTS = 16'h000C;
    localparam logic [15:0] REG_STATUS = 16'h0010;

    localparam int STAT_ERR_BIT  = 31;
    localparam int STAT_DONE_BIT = 30;
    localparam int STAT_BUSY_BIT = 29;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_WAIT, S_RD, S_RD_WAIT, S_PUSH, S_NEXT, S_ERR
    } state_e;

    // Word k of the four sum words: I-lo, I-hi, Q-lo, Q-hi
    function automatic logic [15:0] sum_addr(input logic [1:0] k);
        return SUM_ADDR + {12'd0, k, 2'b00};
    endfunction

endpackage

// File: rtl/na_sweep_sequencer_bus.sv
// Single-outstanding-transaction register-bus master with ack capture and timeout.
// Strobes are issued combinationally in the request cycle; address/data are held afterwards.
module na_bus_master
    import na_sweep_sequencer_pkg::*;
#(
    parameter int TIMEOUTBITS = TIMEOUTBITS_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        timeout_o,
    output logic [15:0] m_addr_o,
    output logic        m_wen_o,
    output logic        m_ren_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_rdata_i
);

    // Last count value before giving up: 2^TIMEOUTBITS-1 waiting cycles in total
    localparam logic [TIMEOUTBITS-1:0] CNT_LAST = {{(TIMEOUTBITS-1){1'b1}}, 1'b0};

    logic                   pend_q, pend_d;
    logic [TIMEOUTBITS-1:0] cnt_q, cnt_d;
    logic [15:0]            addr_q;
    logic [31:0]            wdata_q;
    logic                   issue;

    assign issue     = req_valid_i && !pend_q && !flush_i;
    assign m_wen_o   = issue && req_we_i;
    assign m_ren_o   = issue && !req_we_i;
    assign m_addr_o  = issue ? req_addr_i  : addr_q;
    assign m_wdata_o = issue ? req_wdata_i : wdata_q;
    assign rdata_o   = m_rdata_i;

    always_comb begin
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        if (flush_i) begin
            pend_d = 1'b0;
        end else if (issue) begin
            pend_d = 1'b1;
            cnt_d  = '0;
        end else if (pend_q) begin
            if (m_ack_i) begin
                done_o = 1'b1;
                pend_d = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
                timeout_o = 1'b1;
                pend_d    = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            if (issue) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
        end
    end

endmodule

// File: rtl/na_sweep_sequencer.sv
// Frequency-sweep sequencer: programs each point into the IQ block's averager,
// collects the two 62-bit quadrature sums and streams them out as result beats.
module na_sweep_sequencer
    import na_sweep_sequencer_pkg::*;
#(
    parameter int POINTBITS   = POINTBITS_DEF,
    parameter int TIMEOUTBITS = TIMEOUTBITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           addr,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [31:0]           wdata,
    output logic                  ack,
    output logic [31:0]           rdata,
    output logic [15:0]           m_addr,
    output logic                  m_wen,
    output logic                  m_ren,
    output logic [31:0]           m_wdata,
    input  logic                  m_ack,
    input  logic [31:0]           m_rdata,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [POINTBITS-1:0]  res_idx,
    output logic signed [61:0]    res_i,
    output logic signed [61:0]    res_q
);

    state_e               state_q, state_d;
    logic [31:0]          freq_q, freq_d, start_q, step_q;
    logic [POINTBITS-1:0] points_q, run_pts_q, run_pts_d, idx_q, idx_d, idx_inc;
    logic [1:0]           k_q, k_d;
    logic [30:0]          slot_q [4];
    logic                 slot_we;
    logic                 done_q, done_d, err_q, err_d;
    logic                 ack_q;
    logic [31:0]          rdata_q, rd_mux;
    logic                 ctrl_wr, start_req, abort_req, busy;
    logic                 req_valid, req_we, bm_done, bm_timeout;
    logic [15:0]          req_addr;
    logic [31:0]          req_wdata, bm_rdata;

    assign ctrl_wr   = wen && (addr == REG_CTRL);
    assign abort_req = ctrl_wr && wdata[1];
    assign start_req = ctrl_wr && wdata[0] && !wdata[1];
    assign busy      = (state_q != S_IDLE) && (state_q != S_ERR);
    assign idx_inc   = idx_q + 1'b1;

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign res_valid = (state_q == S_PUSH);
    assign res_idx   = idx_q;
    assign res_i     = signed'({slot_q[1], slot_q[0]});
    assign res_q     = signed'({slot_q[3], slot_q[2]});

    na_bus_master #(.TIMEOUTBITS(TIMEOUTBITS)) u_bus (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (abort_req),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .done_o      (bm_done),
        .rdata_o     (bm_rdata),
        .timeout_o   (bm_timeout),
        .m_addr_o    (m_addr),
        .m_wen_o     (m_wen),
        .m_ren_o     (m_ren),
        .m_wdata_o   (m_wdata),
        .m_ack_i     (m_ack),
        .m_rdata_i   (m_rdata)
    );

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_START:  rd_mux = start_q;
            REG_STEP:   rd_mux = step_q;
            REG_POINTS: rd_mux[POINTBITS-1:0] = points_q;
            REG_STATUS: begin
                rd_mux[POINTBITS-1:0] = idx_q;
                rd_mux[STAT_ERR_BIT]  = err_q;
                rd_mux[STAT_DONE_BIT] = done_q;
                rd_mux[STAT_BUSY_BIT] = busy;
            end
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        freq_d    = freq_q;
        idx_d     = idx_q;
        k_d       = k_q;
        done_d    = done_q;
        err_d     = err_q;
        run_pts_d = run_pts_q;
        slot_we   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = FREQ_ADDR;
        req_wdata = freq_q;
        if (abort_req) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start_req) begin
                        if (points_q == '0) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            freq_d    = start_q;
                            idx_d     = '0;
                            done_d    = 1'b0;
                            err_d     = 1'b0;
                            run_pts_d = points_q;
                            state_d   = S_WR;
                        end
                    end
                end
                S_WR: begin
                    req_valid = 1'b1;
                    req_we    = 1'b1;
                    state_d   = S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (bm_done) begin
                        k_d     = 2'd0;
                        state_d = S_RD;
                    end else if (bm_timeout) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
                S_RD: begin
                    req_valid = 1'b1;
                    req_addr  = sum_addr(k_q);
                    req_wdata = '0;
                    state_d   = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Bit 31 of the I-lo word flags an averaging run still in progress
                    if (bm_done) begin
                        state_d = S_RD;
                        if (!(k_q == 2'd0 && bm_rdata[31])) begin
                            slot_we = 1'b1;
                            if (k_q == 2'd3) state_d = S_PUSH;
                            else             k_d     = k_q + 2'd1;
                        end
                    end else if (bm_timeout) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
                S_PUSH: begin
                    if (res_ready) state_d = S_NEXT;
                end
                S_NEXT: begin
                    freq_d = freq_q + step_q;
                    idx_d  = idx_inc;
                    if (idx_inc == run_pts_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WR;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            freq_q    <= '0;
            idx_q     <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            run_pts_q <= '0;
            start_q   <= '0;
            step_q    <= '0;
            points_q  <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            for (int s = 0; s < 4; s++) slot_q[s] <= '0;
        end else begin
            state_q   <= state_d;
            freq_q    <= freq_d;
            idx_q     <= idx_d;
            k_q       <= k_d;
            done_q    <= done_d;
            err_q     <= err_d;
            run_pts_q <= run_pts_d;
            ack_q     <= wen || ren;
            if (ren) rdata_q <= rd_mux;
            if (slot_we) slot_q[k_q] <= bm_rdata[30:0];
            if (wen) begin
                case (addr)
                    REG_START:  start_q  <= wdata;
                    REG_STEP:   step_q   <= wdata;
                    REG_POINTS: points_q <= wdata[POINTBITS-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_na_sweep_sequencer.sv
// Directed and randomized sweeps against a responder model of the IQ block averager.
module tb_na_sweep_sequencer;
    import na_sweep_sequencer_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [15:0]        addr;
    logic               wen, ren;
    logic [31:0]        wdata;
    logic               ack;
    logic [31:0]        rdata;
    logic [15:0]        m_addr;
    logic               m_wen, m_ren;
    logic [31:0]        m_wdata;
    logic               m_ack = 1'b0;
    logic [31:0]        m_rdata = '0;
    logic               res_valid, res_ready;
    logic [15:0]        res_idx;
    logic signed [61:0] res_i, res_q;

    int vectors = 0;
    int miscompares = 0;

    na_sweep_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr(addr), .wen(wen), .ren(ren), .wdata(wdata),
        .ack(ack), .rdata(rdata), .m_addr(m_addr), .m_wen(m_wen), .m_ren(m_ren),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .res_valid(res_valid),
        .res_ready(res_ready), .res_idx(res_idx), .res_i(res_i), .res_q(res_q)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus knobs (written only by the main initial block)
    bit          resp_on;
    int          poll_cfg;
    bit          fixed_sums;
    logic [61:0] i_base, q_base;
    bit          rdy_rand;
    logic        rdy_fix;
    logic        rdy_rnd = 1'b1;

    assign res_ready = rdy_rand ? rdy_rnd : rdy_fix;
    always @(negedge clk_i) rdy_rnd <= 1'($urandom_range(0, 1));

    // Sums the averager reports for a given frequency word
    function automatic logic [61:0] exp_i(input logic [31:0] f);
        return fixed_sums ? i_base : (i_base ^ {f[29:0], f});
    endfunction
    function automatic logic [61:0] exp_q(input logic [31:0] f);
        return fixed_sums ? q_base : (q_base ^ {f, f[29:0]});
    endfunction

    // Responder: 1-cycle ack, reports "busy" on the first poll_cfg reads of I-lo per point
    logic [31:0] wr_log[$];
    logic [15:0] rd_log[$];
    logic [31:0] last_freq = '0;
    int          polls_left = 0;

    function automatic logic [31:0] resp_word(input logic [15:0] a, input logic [31:0] f,
                                              input bit still_busy, input logic [31:0] junk);
        logic [61:0] iv, qv;
        iv = exp_i(f);
        qv = exp_q(f);
        case (a)
            SUM_ADDR:          return still_busy ? (32'h8000_0000 | junk) : {1'b0, iv[30:0]};
            SUM_ADDR + 16'h4:  return {junk[31], iv[61:31]};
            SUM_ADDR + 16'h8:  return {junk[31], qv[30:0]};
            SUM_ADDR + 16'hC:  return {junk[31], qv[61:31]};
            default:           return junk;
        endcase
    endfunction

    always @(posedge clk_i) begin
        m_ack <= 1'b0;
        if (m_wen && m_addr == FREQ_ADDR) begin
            wr_log.push_back(m_wdata);
            last_freq  <= m_wdata;
            polls_left <= poll_cfg;
        end
        if (m_ren) rd_log.push_back(m_addr);
        if (resp_on && (m_wen || m_ren)) begin
            m_ack   <= 1'b1;
            m_rdata <= resp_word(m_addr, last_freq, polls_left > 0, $urandom);
            if (m_ren && m_addr == SUM_ADDR && polls_left > 0) polls_left <= polls_left - 1;
        end
    end

    typedef struct packed {
        logic [15:0] idx;
        logic [61:0] i;
        logic [61:0] q;
    } beat_t;
    beat_t beats[$];

    always @(posedge clk_i) begin
        if (!rst_i && res_valid && res_ready) beats.push_back({res_idx, res_i, res_q});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ps_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk_i);
        addr = a; wdata = d; wen = 1'b1;
        @(negedge clk_i);
        wen = 1'b0;
    endtask

    task automatic ps_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk_i);
        addr = a; ren = 1'b1;
        @(negedge clk_i);
        ren = 1'b0;
        d = rdata;
        chk("ps_ack", {63'd0, ack}, 64'd1);
    endtask

    task automatic wait_status(input logic [31:0] mask, input int max_reads,
                               output logic [31:0] st, output bit hit);
        hit = 1'b0;
        st  = '0;
        for (int n = 0; n < max_reads && !hit; n++) begin
            ps_read(REG_STATUS, st);
            if ((st & mask) != 0) hit = 1'b1;
        end
    endtask

    task automatic start_sweep(input logic [31:0] f0, input logic [31:0] st, input int pts,
                               output int wb, output int bb);
        ps_write(REG_START, f0);
        ps_write(REG_STEP, st);
        ps_write(REG_POINTS, 32'(pts));
        wb = wr_log.size();
        bb = beats.size();
        ps_write(REG_CTRL, 32'h1);
    endtask

    // Expected: point p writes f0+p*step, beat p carries idx p and the sums for that word
    task automatic verify_sweep(input string tag, input logic [31:0] f0, input logic [31:0] st,
                                input int pts, input int wb, input int bb);
        logic [31:0] s;
        bit hit;
        wait_status(32'hC000_0000, 40 * pts + 40, s, hit);
        chk({tag, "_finished"}, {63'd0, hit}, 64'd1);
        chk({tag, "_status"}, {32'd0, s}, {32'd0, 32'h4000_0000 | 32'(pts)});
        chk({tag, "_nwrites"}, 64'(wr_log.size() - wb), 64'(pts));
        chk({tag, "_nbeats"}, 64'(beats.size() - bb), 64'(pts));
        for (int p = 0; p < pts; p++) begin
            logic [31:0] f;
            f = f0 + st * 32'(p);
            if (wb + p < wr_log.size()) chk({tag, "_freq"}, {32'd0, wr_log[wb + p]}, {32'd0, f});
            if (bb + p < beats.size()) begin
                chk({tag, "_idx"}, {48'd0, beats[bb + p].idx}, 64'(p));
                chk({tag, "_i"}, {2'b00, beats[bb + p].i}, {2'b00, exp_i(f)});
                chk({tag, "_q"}, {2'b00, beats[bb + p].q}, {2'b00, exp_q(f)});
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s, f0, st;
        int wb, bb, rb, n140, pts, nw;
        bit hit, stable;
        logic [15:0]        h_idx;
        logic signed [61:0] h_i, h_q;

        rst_i = 1'b1; addr = '0; wen = 1'b0; ren = 1'b0; wdata = '0;
        rdy_fix = 1'b1; rdy_rand = 1'b0; resp_on = 1'b1; poll_cfg = 0;
        fixed_sums = 1'b1; i_base = 62'h1_2345_6789; q_base = '1;
        repeat (3) @(negedge clk_i);

        chk("rst_ack", {63'd0, ack}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_strobes", {62'd0, m_wen, m_ren}, 64'd0);
        chk("rst_m_addr", {48'd0, m_addr}, 64'd0);
        chk("rst_m_wdata", {32'd0, m_wdata}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_res_data", {48'd0, res_idx} | {2'b00, res_i} | {2'b00, res_q}, 64'd0);
        rst_i = 1'b0;
        ps_read(REG_STATUS, s);  chk("rst_status", {32'd0, s}, 64'd0);
        ps_read(16'h0020, s);    chk("unmapped_read", {32'd0, s}, 64'd0);

        // Directed sweep with fixed sums; also checks start-to-strobe latency
        ps_write(REG_START, 32'd100);
        ps_write(REG_STEP, 32'd50);
        ps_write(REG_POINTS, 32'd3);
        ps_read(REG_START, s);   chk("start_readback", {32'd0, s}, 64'd100);
        ps_read(REG_CTRL, s);    chk("ctrl_reads_zero", {32'd0, s}, 64'd0);
        wb = wr_log.size(); bb = beats.size();
        ps_write(REG_CTRL, 32'h1);
        chk("first_wen", {63'd0, m_wen}, 64'd1);
        chk("first_addr", {48'd0, m_addr}, {48'd0, FREQ_ADDR});
        chk("first_wdata", {32'd0, m_wdata}, 64'd100);
        verify_sweep("directed", 32'd100, 32'd50, 3, wb, bb);

        // Four busy polls before the averager finishes
        poll_cfg = 4;
        rb = rd_log.size();
        start_sweep(32'h1234, 32'h10, 1, wb, bb);
        verify_sweep("poll", 32'h1234, 32'h10, 1, wb, bb);
        n140 = 0;
        for (int j = rb; j < rd_log.size() && rd_log[j] != SUM_ADDR + 16'h4; j++)
            if (rd_log[j] == SUM_ADDR) n140++;
        chk("poll_reads_0x140", 64'(n140), 64'd5);
        poll_cfg = 0;

        // Randomized sweeps with random polling, sums and consumer backpressure
        fixed_sums = 1'b0;
        rdy_rand = 1'b1;
        for (int it = 0; it < 4; it++) begin
            f0 = $urandom; st = $urandom; pts = $urandom_range(1, 4);
            poll_cfg = $urandom_range(0, 3);
            i_base = {30'($urandom), 32'($urandom)};
            q_base = {30'($urandom), 32'($urandom)};
            start_sweep(f0, st, pts, wb, bb);
            verify_sweep("random", f0, st, pts, wb, bb);
        end
        rdy_rand = 1'b0; poll_cfg = 0;

        // Consumer stalls for 20 cycles on the first beat
        rdy_fix = 1'b0;
        start_sweep(32'd7, 32'd3, 2, wb, bb);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk_i);
            hit = res_valid;
        end
        chk("stall_valid_seen", {63'd0, hit}, 64'd1);
        h_idx = res_idx; h_i = res_i; h_q = res_q; nw = wr_log.size();
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            if (!res_valid || res_idx !== h_idx || res_i !== h_i || res_q !== h_q || m_wen) stable = 1'b0;
        end
        chk("stall_stable", {63'd0, stable}, 64'd1);
        chk("stall_no_write", 64'(wr_log.size()), 64'(nw));
        rdy_fix = 1'b1;
        verify_sweep("stall", 32'd7, 32'd3, 2, wb, bb);

        // Reset at point 2 of 5, then a fresh sweep starts from index 0
        start_sweep(32'd1000, 32'd1, 5, wb, bb);
        for (int c = 0; c < 200 && beats.size() - bb < 2; c++) @(negedge clk_i);
        chk("reset_mid_reached", 64'(beats.size() - bb), 64'd2);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_outputs", {58'd0, ack, m_wen, m_ren, res_valid, |rdata, |m_addr}, 64'd0);
        chk("midrst_data", {48'd0, res_idx} | {2'b00, res_i} | {2'b00, res_q} | {32'd0, m_wdata}, 64'd0);
        rst_i = 1'b0;
        ps_read(REG_STATUS, s);  chk("midrst_status", {32'd0, s}, 64'd0);
        start_sweep(32'd500, 32'd5, 2, wb, bb);
        verify_sweep("after_reset", 32'd500, 32'd5, 2, wb, bb);

        // Abort with start set in the same write
        start_sweep(32'd9, 32'd9, 4, wb, bb);
        repeat (6) @(negedge clk_i);
        ps_write(REG_CTRL, 32'h3);
        chk("abort_valid_low", {63'd0, res_valid}, 64'd0);
        ps_read(REG_STATUS, s);
        chk("abort_status_flags", {32'd0, s & 32'hE000_0000}, 64'd0);

        // Responder silent: timeout after 255 waiting cycles
        resp_on = 1'b0;
        start_sweep(32'd77, 32'd1, 2, wb, bb);
        repeat (235) @(negedge clk_i);
        ps_read(REG_STATUS, s);
        chk("timeout_still_busy", {32'd0, s}, 64'h2000_0000);
        wait_status(32'h8000_0000, 40, s, hit);
        chk("timeout_seen", {63'd0, hit}, 64'd1);
        chk("timeout_status", {32'd0, s}, 64'h8000_0000);
        resp_on = 1'b1;
        repeat (3) @(negedge clk_i);
        start_sweep(32'd42, 32'd2, 2, wb, bb);
        verify_sweep("from_err", 32'd42, 32'd2, 2, wb, bb);

        // Zero points: done without any bus activity
        rb = rd_log.size(); nw = wr_log.size();
        start_sweep(32'd1, 32'd1, 0, wb, bb);
        repeat (10) @(negedge clk_i);
        chk("zero_pts_no_strobes", 64'(rd_log.size() - rb + wr_log.size() - nw), 64'd0);
        ps_read(REG_STATUS, s);
        chk("zero_pts_done", {32'd0, s & 32'hE000_0000}, 64'h4000_0000);

        // Frequency accumulator wraps modulo 2^32
        start_sweep(32'hFFFF_FFF0, 32'h20, 2, wb, bb);
        verify_sweep("wrap", 32'hFFFF_FFF0, 32'h20, 2, wb, bb);
        if (wb + 1 < wr_log.size()) chk("wrap_second_word", {32'd0, wr_log[wb + 1]}, 64'h10);
        else chk("wrap_second_word_missing", 64'(wr_log.size()), 64'(wb + 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
